// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that writes instruction memory from a framed byte stream
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        error
);
    localparam logic [2:0] S_HDR0 = 3'd0;
    localparam logic [2:0] S_HDR1 = 3'd1;
    localparam logic [2:0] S_CHK  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [15:0] word_cnt;
    logic [1:0]  lane;
    logic [23:0] wbuf;
    logic [7:0]  csum;
    logic [31:0] next_addr;
    logic        take;

    // bytes are only taken in receiving states, and never while reset is held
    always_comb begin
        in_ready = reset && (state == S_HDR0 || state == S_HDR1 || state == S_DATA || state == S_CSUM);
        take     = in_valid && in_ready;
    end

    // frame sequencer: header, size check, word assembly with memory writes, checksum verdict
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_HDR0;
            cnt       <= '0;
            word_cnt  <= '0;
            lane      <= '0;
            wbuf      <= '0;
            csum      <= '0;
            next_addr <= BASE_ADDR;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_HDR0: if (take) begin
                    cnt[7:0] <= in_data;
                    state    <= S_HDR1;
                end
                S_HDR1: if (take) begin
                    cnt[15:8] <= in_data;
                    state     <= S_CHK;
                end
                S_CHK: begin
                    if (cnt > MAX_N) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else begin
                        state <= (cnt == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: if (take) begin
                    csum <= csum ^ in_data;
                    lane <= lane + 2'd1;
                    if (lane == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= next_addr;
                        mem_wdata <= {in_data, wbuf};
                        next_addr <= next_addr + 32'd4;
                        word_cnt  <= word_cnt + 16'd1;
                        if (word_cnt == cnt - 16'd1)
                            state <= S_CSUM;
                    end else begin
                        wbuf <= {in_data, wbuf[23:8]};
                    end
                end
                S_CSUM: if (take) begin
                    if (in_data == csum) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames checked against a byte-stream reference model
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, core_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;
    logic        in_ready1, mem_we1, core_hold1, done1, error1;
    logic [31:0] mem_addr1, mem_wdata1;
    int          passed = 0;
    int          total = 0;
    int          acc = 0;
    logic [31:0] wa[$], wd[$], wa1[$], wd1[$];
    logic [31:0] fixed_q[$] = '{32'h0000_0013, 32'hDEAD_BEEF};
    logic [31:0] empty_q[$];

    always #5 clk = ~clk;

    imem_loader u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .done(done), .error(error)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .core_hold(core_hold1), .done(done1), .error(error1)
    );

    // monitor: count consumed bytes and log every memory write
    always @(negedge clk) begin
        if (in_valid && in_ready) acc++;
        if (mem_we) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end
        if (mem_we1) begin wa1.push_back(mem_addr1); wd1.push_back(mem_wdata1); end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_addr1", mem_addr1, 32'h100);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_core_hold", 32'(core_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wa.delete(); wd.delete(); wa1.delete(); wd1.delete();
    endtask

    task automatic offer_extra(input string tag);
        int a0 = acc;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (4) begin @(posedge clk); #1; end
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        chk({tag, "_consumed"}, 32'(acc - a0), 32'd0);
    endtask

    // reference: frame bytes, checksum and expected writes come straight from the word list
    task automatic run_frame(input logic [31:0] words[$], input bit bad, input int maxgap);
        int          n = words.size();
        logic [15:0] n16 = 16'(n);
        logic [7:0]  bytes[$];
        logic [7:0]  x = 8'h00;
        bytes.push_back(n16[7:0]);
        bytes.push_back(n16[15:8]);
        foreach (words[i])
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w = words[i];
                bytes.push_back(w[8*k +: 8]);
                x ^= w[8*k +: 8];
            end
        bytes.push_back(bad ? (x ^ 8'h01) : x);
        foreach (bytes[i]) send_byte(bytes[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        chk("verdict_done", 32'(done), 32'(!bad));
        chk("verdict_error", 32'(error), 32'(bad));
        chk("verdict_hold", 32'(core_hold), 32'(bad));
        chk("verdict_done1", 32'(done1), 32'(!bad));
        repeat (2) begin @(posedge clk); #1; end
        chk("write_count", 32'(wa.size()), 32'(n));
        chk("write_count1", 32'(wa1.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size() && i < wa1.size(); i++) begin
            chk("write_addr", wa[i], 32'(4 * i));
            chk("write_data", wd[i], words[i]);
            chk("write_addr1", wa1[i], 32'h100 + 32'(4 * i));
            chk("write_data1", wd1[i], words[i]);
        end
        offer_extra("after_frame");
        chk("sticky_done", 32'(done), 32'(!bad));
        chk("sticky_error", 32'(error), 32'(bad));
    endtask

    initial begin
        logic [31:0] rq[$];
        #2;
        do_reset();
        run_frame(fixed_q, 1'b0, 0);
        do_reset();
        run_frame(fixed_q, 1'b1, 0);
        do_reset();
        run_frame(empty_q, 1'b0, 0);
        do_reset();
        rq = '{$urandom};
        run_frame(rq, 1'b0, 0);
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("ovf_chk_ready", 32'(in_ready), 32'd0);
        chk("ovf_chk_error", 32'(error), 32'd0);
        @(posedge clk); #1;
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_hold", 32'(core_hold), 32'd1);
        offer_extra("ovf_payload");
        chk("ovf_no_write", 32'(wa.size()), 32'd0);
        do_reset();
        run_frame(fixed_q, 1'b0, 5);
        for (int t = 0; t < 3; t++) begin
            do_reset();
            rq.delete();
            repeat ($urandom_range(1, 8)) rq.push_back($urandom);
            run_frame(rq, 1'($urandom_range(0, 1)), 3);
        end
        do_reset();
        rq.delete();
        repeat (256) rq.push_back($urandom);
        run_frame(rq, 1'b0, 0);
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        do_reset();
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_no_write", 32'(wa.size()), 32'd0);
        run_frame(fixed_q, 1'b0, 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
